// File: rtl/display_pager_pkg.sv
// Shared constants, debounce state encoding and page-slice helper for the pager.
package display_pager_pkg;

  localparam int NIBBLES_PER_PAGE = 8;
  localparam int PAGES            = 4;
  localparam int PAGE_W           = 2;
  localparam int PAGE_BITS        = NIBBLES_PER_PAGE * 4;

  localparam int TICK_DIV_DEF = 50000000;
  localparam int DEBOUNCE_DEF = 1000000;

  typedef enum logic [1:0] {
    DB_UP      = 2'd0,
    DB_WAIT_DN = 2'd1,
    DB_DOWN    = 2'd2,
    DB_WAIT_UP = 2'd3
  } db_state_t;

  // Page 0 is the most significant word of the block.
  function automatic logic [PAGE_BITS-1:0] page_slice(input logic [PAGES*PAGE_BITS-1:0] blk,
                                                      input logic [PAGE_W-1:0] p);
    return blk[(PAGES - 1 - int'(p)) * PAGE_BITS +: PAGE_BITS];
  endfunction

endpackage

// File: rtl/display_pager_key_debounce.sv
// Push-button synchronizer and debouncer; one press pulse per accepted key-down.
//
// state      | meaning
// -----------+---------------------------------------------------
// DB_UP      | key released and stable
// DB_WAIT_DN | key seen low, counting consecutive low cycles
// DB_DOWN    | key pressed and stable (press already reported)
// DB_WAIT_UP | key seen high, counting consecutive high cycles
module key_debounce
  import display_pager_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
  localparam logic [CNT_W-1:0] LIM = CNT_W'(DEBOUNCE - 1);

  logic sync1, sync2;
  db_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // Two-flop synchronizer; resets to the released level so reset never fakes a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // State and stability-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DB_UP;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state; the cycle that first sees a level change counts as the first stable cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    press     = 1'b0;
    case (state)
      DB_UP: begin
        if (!sync2) begin
          state_nxt = DB_WAIT_DN;
          cnt_nxt   = CNT_W'(1);
        end
      end
      DB_WAIT_DN: begin
        if (sync2) begin
          state_nxt = DB_UP;
          cnt_nxt   = '0;
        end else if (cnt >= LIM) begin
          state_nxt = DB_DOWN;
          cnt_nxt   = '0;
          press     = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DB_DOWN: begin
        if (sync2) begin
          state_nxt = DB_WAIT_UP;
          cnt_nxt   = CNT_W'(1);
        end
      end
      DB_WAIT_UP: begin
        if (!sync2) begin
          state_nxt = DB_DOWN;
          cnt_nxt   = '0;
        end else if (cnt >= LIM) begin
          state_nxt = DB_UP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = DB_UP;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/display_pager.sv
// Shows a 128-bit block as four 8-digit pages, stepped by key press or auto timer.
module display_pager
  import display_pager_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [PAGES*PAGE_BITS-1:0]     data_in,
  input  logic                           data_valid,
  input  logic                           key_n,
  input  logic                           auto_en,
  output logic [PAGE_BITS-1:0]           digits,
  output logic [PAGE_W-1:0]              page,
  output logic                           loaded
);

  localparam int TMR_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TMR_W-1:0] TC = TMR_W'(TICK_DIV - 1);

  logic                         press, tick, run;
  logic [TMR_W-1:0]             timer, timer_nxt;
  logic [PAGES*PAGE_BITS-1:0]   blk, blk_nxt;
  logic [PAGE_W-1:0]            page_nxt;
  logic                         loaded_nxt;
  logic [PAGE_BITS-1:0]         digits_nxt;

  key_debounce #(.DEBOUNCE(DEBOUNCE)) u_key (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_n),
    .press (press)
  );

  // Auto timer, page selection and the digit word it implies; a new block wins over any advance.
  always_comb begin
    run       = auto_en && loaded;
    tick      = run && (timer == TC);
    timer_nxt = timer + TMR_W'(1);
    if (!run || data_valid || press || tick) timer_nxt = '0;

    blk_nxt    = blk;
    page_nxt   = page;
    loaded_nxt = loaded;
    if (data_valid) begin
      blk_nxt    = data_in;
      page_nxt   = '0;
      loaded_nxt = 1'b1;
    end else if (loaded && (press || tick)) begin
      page_nxt = page + PAGE_W'(1);
    end

    digits_nxt = loaded_nxt ? page_slice(blk_nxt, page_nxt) : '0;
  end

  // All visible state is registered so the decoders see glitch-free digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer  <= '0;
      blk    <= '0;
      page   <= '0;
      loaded <= 1'b0;
      digits <= '0;
    end else begin
      timer  <= timer_nxt;
      blk    <= blk_nxt;
      page   <= page_nxt;
      loaded <= loaded_nxt;
      digits <= digits_nxt;
    end
  end

endmodule

// File: tb/tb_display_pager.sv
// Randomized self-checking bench for display_pager against a page/block reference model.
module tb_display_pager;

  localparam int TB_DEB  = 4;
  localparam int TB_TICK = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] data_in;
  logic         data_valid;
  logic         key_n;
  logic         auto_en;
  logic [31:0]  digits;
  logic [1:0]   page;
  logic         loaded;

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] m_block;
  int           m_page;
  bit           m_loaded;

  always #5 clk = ~clk;

  display_pager #(.TICK_DIV(TB_TICK), .DEBOUNCE(TB_DEB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .key_n      (key_n),
    .auto_en    (auto_en),
    .digits     (digits),
    .page       (page),
    .loaded     (loaded)
  );

  function automatic logic [31:0] m_digits();
    logic [127:0] t;
    if (!m_loaded) return 32'h0;
    t = m_block >> (32 * (3 - m_page));
    return t[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".digits"}, digits, m_digits());
    chk({tag, ".page"}, {30'b0, page}, 32'(m_page));
    chk({tag, ".loaded"}, {31'b0, loaded}, {31'b0, m_loaded});
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic advance();
    if (m_loaded) m_page = (m_page + 1) % 4;
  endtask

  function automatic logic [127:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic load(input logic [127:0] b);
    data_in    = b;
    data_valid = 1'b1;
    cyc(1);
    data_valid = 1'b0;
    m_block    = b;
    m_page     = 0;
    m_loaded   = 1'b1;
  endtask

  // A low run of len cycles counts as one press iff len >= DEBOUNCE.
  task automatic key_pulse(input int len);
    key_n = 1'b0;
    cyc(len);
    key_n = 1'b1;
    cyc(TB_DEB + 8);
    if (len >= TB_DEB) advance();
  endtask

  logic [31:0] exp_tab [4] = '{32'h44556677, 32'h8899AABB, 32'hCCDDEEFF, 32'h00112233};

  initial begin
    rst_n      = 1'b0;
    data_in    = '0;
    data_valid = 1'b0;
    key_n      = 1'b1;
    auto_en    = 1'b0;
    m_block    = '0;
    m_page     = 0;
    m_loaded   = 1'b0;

    cyc(3);
    check_all("reset");
    rst_n = 1'b1;
    cyc(2);

    key_pulse(10);
    check_all("press_unloaded");

    load(128'h00112233_445566778899AABB_CCDDEEFF);
    check_all("first_load");
    chk("first_load.const", digits, 32'h00112233);

    for (int i = 0; i < 4; i++) begin
      key_pulse(TB_DEB + int'($urandom_range(0, 8)));
      check_all("press_seq");
      chk("press_seq.const", digits, exp_tab[i]);
    end

    key_pulse(3);
    check_all("glitch3");
    key_pulse(100);
    check_all("hold100");

    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 2) == 0) load(rand_block());
      else key_pulse(int'($urandom_range(1, 14)));
      check_all("random");
    end

    // Auto-advance: edge L loads, ticks land on L+10, L+20, ...
    auto_en = 1'b1;
    load(rand_block());
    check_all("auto_L");
    cyc(9);
    check_all("auto_L9");
    cyc(1);
    advance();
    check_all("auto_L10");
    cyc(4);
    key_n = 1'b0;               // press lands on edge L+20 together with the tick
    cyc(6);
    advance();
    check_all("tick_and_press");
    cyc(2);
    key_n = 1'b1;
    cyc(7);
    data_in    = rand_block();  // data_valid on the L+30 tick, page is 2
    data_valid = 1'b1;
    cyc(1);
    data_valid = 1'b0;
    m_block    = data_in;
    m_page     = 0;
    check_all("valid_on_tick");
    cyc(9);
    check_all("after_valid9");
    cyc(1);
    advance();
    check_all("after_valid10");

    // Reset in the middle of a debounce and a timer count.
    cyc(3);
    key_n = 1'b0;
    cyc(2);
    rst_n = 1'b0;
    #1;
    m_block  = '0;
    m_page   = 0;
    m_loaded = 1'b0;
    check_all("async_reset");
    cyc(2);
    auto_en = 1'b0;
    rst_n   = 1'b1;
    load(rand_block());
    cyc(4);
    check_all("held_after_reset_early");
    cyc(1);
    advance();
    check_all("held_after_reset_press");
    key_n = 1'b1;
    cyc(12);
    check_all("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/display_pager.md
DISPLAY_PAGER -- requirements
Module: display_pager

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, meaning clock cycles per auto-advance step (1 s at 50 MHz).
REQ-002 SHALL have parameter DEBOUNCE, default 1000000, meaning cycles the key input must be stable before a level is accepted (20 ms at 50 MHz).
REQ-003 SHALL use one clock, with asynchronous active-low reset.
REQ-004 SHALL have port: clk  input  1  rising-edge system clock.
REQ-005 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port: data_in  input  128  cipher/plain block to display.
REQ-007 SHALL have port: data_valid  input  1  single-cycle strobe; data_in is captured on this cycle.
REQ-008 SHALL have port: key_n  input  1  raw asynchronous push-button, low = pressed.
REQ-009 SHALL have port: auto_en  input  1  level; 1 = timed auto-advance.
REQ-010 SHALL have port: digits  output  32  eight nibbles for eight downstream nibble-to-7-segment decoders; [31:28] = leftmost digit.
REQ-011 SHALL have port: page  output  2  current page index, 0..3.
REQ-012 SHALL have port: loaded  output  1  high once a block has been captured since reset.

Function
REQ-013 Page p SHALL present block bits [127-32p : 96-32p] on digits: page 0 = [127:96], page 3 = [31:0].
REQ-014 On data_valid: block register SHALL load data_in, page SHALL go to 0, auto timer SHALL clear, and loaded SHALL set; digits SHALL show the new page 0 on the next cycle (1-cycle latency).
REQ-015 key_n SHALL pass through a 2-flop synchronizer before any other use.
REQ-016 The debouncer SHALL be a 4-state FSM:
- UP -> WAIT_DN when the synced key is 0.
- WAIT_DN -> DOWN after DEBOUNCE consecutive cycles low; WAIT_DN -> UP if the key returns high first.
- DOWN -> WAIT_UP when the key is 1.
- WAIT_UP -> UP after DEBOUNCE consecutive cycles high; WAIT_UP -> DOWN if the key goes low first.
REQ-017 The WAIT_DN -> DOWN transition SHALL emit a one-cycle press pulse; holding the key SHALL produce exactly one pulse.
REQ-018 While auto_en=1 and loaded=1, the timer SHALL count 0..TICK_DIV-1 and emit a tick on reaching TICK_DIV-1, then return to 0.
REQ-019 While auto_en=0 or loaded=0, the timer SHALL be held at 0.
REQ-020 A press or tick SHALL advance page by 1, wrapping 3 -> 0; digits SHALL update the following cycle.
REQ-021 A press SHALL also clear the timer.
REQ-022 Press and tick in the same cycle SHALL advance page by exactly 1.
REQ-023 data_valid coinciding with a press or tick SHALL take priority; page SHALL become 0 and no advance SHALL occur.
REQ-024 Press and tick SHALL be ignored while loaded=0; digits SHALL be 32'h0 while loaded=0.
REQ-025 digits, page, and loaded SHALL be registered outputs.

Reset
REQ-026 While rst_n=0, all of the following SHALL hold asynchronously:
- Block register, digits, timer, and debounce counter = 0.
- page = 0 and loaded = 0.
- Debounce FSM in UP; synchronizer flops = 1.
REQ-027 Reset asserted mid-debounce or mid-count SHALL discard the partial state; a held key after reset release SHALL require a full DEBOUNCE period before it counts as a press.

Structure
REQ-028 A shared display package SHALL hold:
- NIBBLES_PER_PAGE = 8, PAGES = 4, PAGE_W = 2.
- Default TICK_DIV and DEBOUNCE values.
- The debounce state enumeration.
REQ-029 The synchronizer and debounce FSM SHALL be one sub-module, key_debounce (in: clk, rst_n, key_n; out: press), reusable for other board keys.

Verification
REQ-030 Bench SHALL apply reset, then data_valid with data_in=128'h00112233_445566778899AABB_CCDDEEFF -> next cycle digits=32'h00112233, page=0, loaded=1.
REQ-031 Bench SHALL run with DEBOUNCE=4 and auto_en=0, giving 4 clean presses -> digits 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF, 32'h00112233, page 1, 2, 3, 0.
REQ-032 Bench SHALL apply a 3-cycle low glitch on key_n (DEBOUNCE=4) -> no page change; a key held low for 100 cycles -> exactly one advance.
REQ-033 Bench SHALL set TICK_DIV=10 and auto_en=1 -> page advances every 10 cycles; forcing a press on the same cycle as a tick -> page advances by 1 only.
REQ-034 Bench SHALL assert data_valid on the tick cycle while page=2 -> page=0 with the new block shown, and no advance.
REQ-035 Bench SHALL press the key before any data_valid -> digits stay 32'h0 and page stays 0; asserting rst_n low mid-count -> all outputs 0 immediately.
